register_file_2r1w: RTL and testbench

//  Synchronous parametrised register file: 2**Depth words of Width bits, one write port, two read ports.

---
 rtl/register_file_pkg.sv | 13 +
 rtl/register_file_2r1w_clear_seq.sv | 57 +++++
 rtl/register_file_2r1w.sv | 114 +++++++++++
 tb/tb_register_file_2r1w.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared types and helpers for the 2-read/1-write register file and its clear sequencer.
package register_file_pkg;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    function automatic int rf_num_bytes(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/register_file_2r1w_clear_seq.sv
// Bulk-clear sequencer: walks every entry once, ascending, and owns the array write port while busy.
module rf_clear_seq
    import register_file_pkg::*;
#(
    parameter int Depth = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    output logic             busy_o,
    output logic             clr_we_o,
    output logic [Depth-1:0] clr_addr_o
);

    rf_state_e        state_q, state_d;
    logic [Depth-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_o     = 1'b0;
        clr_we_o   = 1'b0;
        clr_addr_o = cnt_q;
        case (state_q)
            RF_IDLE: begin
                if (clear_i) begin
                    state_d = RF_CLEAR;
                    cnt_d   = '0;
                end
            end
            RF_CLEAR: begin
                // clear_i is deliberately not looked at here so a pulse cannot restart the walk
                busy_o   = 1'b1;
                clr_we_o = 1'b1;
                cnt_d    = cnt_q + Depth'(1);
                if (cnt_q == '1) begin
                    state_d = RF_IDLE;
                end
            end
            default: begin
                state_d = RF_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/register_file_2r1w.sv
// Register file, 2**Depth x Width, one byte-enabled write port, two registered read ports with
// write-first bypass; contents are defined by the hardware clear sequence after reset.
module register_file_2r1w
    import register_file_pkg::*;
#(
    parameter int              Width      = 8,
    parameter int              Depth      = 5,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           cs_ni,
    input  logic                           clear_i,
    output logic                           busy_o,
    input  logic                           we_i,
    input  logic [rf_num_bytes(Width)-1:0] wbe_i,
    input  logic [Depth-1:0]               waddr_i,
    input  logic [Width-1:0]               wdata_i,
    input  logic                           oe_a_i,
    input  logic [Depth-1:0]               raddr_a_i,
    output logic [Width-1:0]               rdata_a_o,
    output logic                           rvalid_a_o,
    input  logic                           oe_b_i,
    input  logic [Depth-1:0]               raddr_b_i,
    output logic [Width-1:0]               rdata_b_o,
    output logic                           rvalid_b_o
);

    localparam int NumBytes = rf_num_bytes(Width);
    localparam int Entries  = 2 ** Depth;

    if (Width % 8 != 0) begin : g_width_check
        $error("register_file_2r1w: Width must be a multiple of 8");
    end

    logic             busy;
    logic             clr_we;
    logic [Depth-1:0] clr_addr;

    rf_clear_seq #(
        .Depth(Depth)
    ) u_clear_seq (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (clear_i),
        .busy_o     (busy),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    assign busy_o = busy;

    logic [Width-1:0] mem_q [Entries];

    logic             user_we;
    logic             rd_a_acc, rd_b_acc;
    logic [Width-1:0] merged;
    logic             arr_we;
    logic [Depth-1:0] arr_addr;
    logic [Width-1:0] arr_wdata;
    logic [Width-1:0] word_a, word_b;
    logic [Width-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
    logic             rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;

    always_comb begin
        user_we  = !rst_i && !busy && !cs_ni && we_i;
        rd_a_acc = !busy && !cs_ni && oe_a_i;
        rd_b_acc = !busy && !cs_ni && oe_b_i;

        merged = '0;
        for (int k = 0; k < NumBytes; k++) begin
            merged[8*k +: 8] = wbe_i[k] ? wdata_i[8*k +: 8] : mem_q[waddr_i][8*k +: 8];
        end

        // The sequencer and user writes are mutually exclusive because user_we requires !busy
        arr_we    = clr_we || user_we;
        arr_addr  = clr_we ? clr_addr : waddr_i;
        arr_wdata = clr_we ? ResetValue : merged;

        word_a = (user_we && (raddr_a_i == waddr_i)) ? merged : mem_q[raddr_a_i];
        word_b = (user_we && (raddr_b_i == waddr_i)) ? merged : mem_q[raddr_b_i];

        rdata_a_d  = rd_a_acc ? word_a : rdata_a_q;
        rdata_b_d  = rd_b_acc ? word_b : rdata_b_q;
        rvalid_a_d = rd_a_acc;
        rvalid_b_d = rd_b_acc;
    end

    always_ff @(posedge clk_i) begin
        if (arr_we) begin
            mem_q[arr_addr] <= arr_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
        end
    end

    assign rdata_a_o  = rdata_a_q;
    assign rdata_b_o  = rdata_b_q;
    assign rvalid_a_o = rvalid_a_q;
    assign rvalid_b_o = rvalid_b_q;

endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed bench for register_file_2r1w: an 8-bit instance for most scenarios, a 16-bit one for byte enables.
module tb_register_file_2r1w;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // 8-bit instance
    logic       rst = 1'b1, cs_n = 1'b0, clr = 1'b0, we = 1'b0;
    logic [0:0] wbe = 1'b1;
    logic [4:0] waddr = '0, ra = '0, rb = '0;
    logic [7:0] wdata = '0;
    logic       oe_a = 1'b0, oe_b = 1'b0;
    logic [7:0] rda, rdb;
    logic       rva, rvb, busy;

    // 16-bit instance
    logic        cs16_n = 1'b0, we16 = 1'b0;
    logic [1:0]  wbe16 = 2'b11;
    logic [4:0]  wa16 = '0, ra16 = '0, rb16 = '0;
    logic [15:0] wd16 = '0;
    logic        oe16_a = 1'b0, oe16_b = 1'b0;
    logic [15:0] rd16_a, rd16_b;
    logic        rv16_a, rv16_b, busy16;

    register_file_2r1w #(.Width(8), .Depth(5), .ResetValue(8'h00)) dut (
        .clk_i(clk), .rst_i(rst), .cs_ni(cs_n), .clear_i(clr), .busy_o(busy),
        .we_i(we), .wbe_i(wbe), .waddr_i(waddr), .wdata_i(wdata),
        .oe_a_i(oe_a), .raddr_a_i(ra), .rdata_a_o(rda), .rvalid_a_o(rva),
        .oe_b_i(oe_b), .raddr_b_i(rb), .rdata_b_o(rdb), .rvalid_b_o(rvb)
    );

    register_file_2r1w #(.Width(16), .Depth(5), .ResetValue(16'h0000)) dut16 (
        .clk_i(clk), .rst_i(rst), .cs_ni(cs16_n), .clear_i(clr), .busy_o(busy16),
        .we_i(we16), .wbe_i(wbe16), .waddr_i(wa16), .wdata_i(wd16),
        .oe_a_i(oe16_a), .raddr_a_i(ra16), .rdata_a_o(rd16_a), .rvalid_a_o(rv16_a),
        .oe_b_i(oe16_b), .raddr_b_i(rb16), .rdata_b_o(rd16_b), .rvalid_b_o(rv16_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cs_n = 1'b0; clr = 1'b0; we = 1'b0; wbe = 1'b1; oe_a = 1'b0; oe_b = 1'b0;
        cs16_n = 1'b0; we16 = 1'b0; wbe16 = 2'b11; oe16_a = 1'b0; oe16_b = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, rva, rvb, rda, rdb} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL reset_state: busy=%b rva=%b rvb=%b rda=%h rdb=%h, want 1 0 0 00 00",
                     busy, rva, rvb, rda, rdb);
        end
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL reset_busy_len: busy cycles=%0d, want 32", n);
        end
        checks++;
        if (busy16 !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy16: busy16=%b, want 0", busy16);
        end
        for (int i = 0; i < 32; i++) begin
            oe_a = 1'b1; oe_b = 1'b1; ra = 5'(i); rb = 5'(i);
            tick();
            checks++;
            if ({rva, rda, rvb, rdb} !== {1'b1, 8'h00, 1'b1, 8'h00}) begin
                errors++;
                $display("FAIL reset_read[%0d]: a=%b/%h b=%b/%h, want 1/00 1/00", i, rva, rda, rvb, rdb);
            end
        end
        idle();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 32; i++) begin
            we = 1'b1; wbe = 1'b1; waddr = 5'(i); wdata = 8'(i);
            tick();
        end
        idle();
        for (int i = 0; i < 32; i++) begin
            oe_a = 1'b1; oe_b = 1'b1; ra = 5'(i); rb = 5'(31 - i);
            tick();
            checks++;
            if ({rva, rda, rvb, rdb} !== {1'b1, 8'(i), 1'b1, 8'(31 - i)}) begin
                errors++;
                $display("FAIL fill_read[%0d]: a=%b/%h b=%b/%h, want 1/%h 1/%h",
                         i, rva, rda, rvb, rdb, 8'(i), 8'(31 - i));
            end
        end
        idle();
        tick();
        checks++;
        if ({rva, rda, rvb, rdb} !== {1'b0, 8'h1F, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL fill_hold: a=%b/%h b=%b/%h, want 0/1f 0/00", rva, rda, rvb, rdb);
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; wbe = 1'b1; waddr = 5'd7; wdata = 8'h5A;
        oe_a = 1'b1; ra = 5'd7; oe_b = 1'b1; rb = 5'd7;
        tick();
        checks++;
        if ({rva, rda, rvb, rdb} !== {1'b1, 8'h5A, 1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL bypass_same_addr: a=%b/%h b=%b/%h, want 1/5a 1/5a", rva, rda, rvb, rdb);
        end
        waddr = 5'd8; wdata = 8'hC3; ra = 5'd9; rb = 5'd8;
        tick();
        checks++;
        if ({rda, rdb} !== {8'h09, 8'hC3}) begin
            errors++;
            $display("FAIL bypass_other_addr: rda=%h rdb=%h, want 09 c3", rda, rdb);
        end
        idle();
        oe_a = 1'b1; ra = 5'd7;
        tick();
        checks++;
        if ({rva, rda} !== {1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL bypass_committed: a=%b/%h, want 1/5a", rva, rda);
        end
        idle();
    endtask

    task automatic test_byte_enable();
        we16 = 1'b1; wa16 = 5'd3; wd16 = 16'hAAAA; wbe16 = 2'b11;
        tick();
        wd16 = 16'h1234; wbe16 = 2'b01;
        tick();
        idle();
        oe16_a = 1'b1; ra16 = 5'd3;
        tick();
        checks++;
        if ({rv16_a, rd16_a} !== {1'b1, 16'hAA34}) begin
            errors++;
            $display("FAIL byte_enable_low: a=%b/%h, want 1/aa34", rv16_a, rd16_a);
        end
        idle();
        we16 = 1'b1; wa16 = 5'd3; wd16 = 16'h5600; wbe16 = 2'b10;
        oe16_b = 1'b1; rb16 = 5'd3;
        tick();
        checks++;
        if ({rv16_b, rd16_b} !== {1'b1, 16'h5634}) begin
            errors++;
            $display("FAIL byte_enable_bypass: b=%b/%h, want 1/5634", rv16_b, rd16_b);
        end
        idle();
        oe16_a = 1'b1; ra16 = 5'd3;
        tick();
        checks++;
        if (rd16_a !== 16'h5634) begin
            errors++;
            $display("FAIL byte_enable_high: rda=%h, want 5634", rd16_a);
        end
        idle();
    endtask

    task automatic test_chip_select();
        oe_a = 1'b1; ra = 5'd10;
        tick();
        checks++;
        if ({rva, rda} !== {1'b1, 8'h0A}) begin
            errors++;
            $display("FAIL cs_preread: a=%b/%h, want 1/0a", rva, rda);
        end
        cs_n = 1'b1; we = 1'b1; waddr = 5'd10; wdata = 8'hFF; oe_b = 1'b1; rb = 5'd10;
        tick();
        checks++;
        if ({rva, rda, rvb} !== {1'b0, 8'h0A, 1'b0}) begin
            errors++;
            $display("FAIL cs_deselect: a=%b/%h rvb=%b, want 0/0a 0", rva, rda, rvb);
        end
        idle();
        oe_a = 1'b1; ra = 5'd10;
        tick();
        checks++;
        if ({rva, rda} !== {1'b1, 8'h0A}) begin
            errors++;
            $display("FAIL cs_no_write: a=%b/%h, want 1/0a", rva, rda);
        end
        idle();
    endtask

    task automatic test_clear_reset();
        int n;
        cs_n = 1'b1; clr = 1'b1;
        tick();
        idle();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_start: busy=%b, want 1", busy);
        end
        for (int i = 0; i < 9; i++) begin
            oe_a = 1'b1; ra = 5'd10;
            tick();
            checks++;
            if ({busy, rva, rda} !== {1'b1, 1'b0, 8'h0A}) begin
                errors++;
                $display("FAIL clear_read_blocked[%0d]: busy=%b a=%b/%h, want 1 0/0a", i, busy, rva, rda);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, rva, rda} !== {1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL clear_reset_edge: busy=%b a=%b/%h, want 1 0/00", busy, rva, rda);
        end
        idle();
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 3) begin
                clr = 1'b1; we = 1'b1; waddr = 5'd0; wdata = 8'hFF; oe_a = 1'b1; ra = 5'd0;
            end
            tick();
            if (n == 3) begin
                checks++;
                if ({rva, rda} !== {1'b0, 8'h00}) begin
                    errors++;
                    $display("FAIL clear_busy_read: a=%b/%h, want 0/00", rva, rda);
                end
            end
            idle();
        end
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL clear_busy_len: busy cycles=%0d, want 32", n);
        end
        for (int i = 0; i < 32; i++) begin
            oe_a = 1'b1; oe_b = 1'b1; ra = 5'(i); rb = 5'(31 - i);
            tick();
            checks++;
            if ({rva, rda, rvb, rdb} !== {1'b1, 8'h00, 1'b1, 8'h00}) begin
                errors++;
                $display("FAIL clear_read[%0d]: a=%b/%h b=%b/%h, want 1/00 1/00", i, rva, rda, rvb, rdb);
            end
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = 8'(1 << i);
            tick();
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            oe_b = 1'b1; rb = 5'(i);
            tick();
            checks++;
            if ({rvb, rdb} !== {1'b1, 8'(1 << i)}) begin
                errors++;
                $display("FAIL walking_one[%0d]: b=%b/%h, want 1/%h", i, rvb, rdb, 8'(1 << i));
            end
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        test_reset();
        test_fill();
        test_bypass();
        test_byte_enable();
        test_chip_select();
        test_clear_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
